// File: rtl/datamem_resp_if.sv
// Request/response bus between a CPU load/store unit (master) and the data-memory responder (slave).
interface datamem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  modport master (
    output req_valid, req_addr, req_we, req_be, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, rd_count, wr_count
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_be, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, rd_count, wr_count
  );
endinterface

// File: rtl/datamem_resp.sv
// Multi-cycle data-memory responder with byte-lane writes and configurable latency.
// Define DATAMEM_STATS_EN to enable saturating completed read/write counters.
module datamem_resp #(
  parameter int ADDR_WIDTH = 17,
  parameter int LATENCY    = 2
) (
  input  logic           clk,
  input  logic           rst,
  datamem_resp_if.slave  bus
);
  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [3:0]  r_be;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic                  w_req_ready;
  logic                  w_resp_valid;
  logic                  w_accept;
  logic                  w_access;
  logic                  w_done;
  logic                  w_oob;
  logic [ADDR_WIDTH-3:0] w_idx;

  assign w_idx    = r_addr[ADDR_WIDTH-1:2];
  assign w_oob    = |r_addr[31:ADDR_WIDTH];
  assign w_accept = bus.req_valid & w_req_ready;
  assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_done   = (r_state == RESP) && bus.resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = WAIT;
      WAIT:    if (r_cnt == 4'd0) w_next = RESP;
      RESP:    if (bus.resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // req_ready must also fall while rst is held, not just once state settles.
  always_comb begin
    w_req_ready  = (r_state == IDLE) && !rst;
    w_resp_valid = (r_state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_we    <= bus.req_we;
      r_be    <= bus.req_be;
      r_cnt   <= 4'(LATENCY - 1);
    end else if (r_state == WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_access) begin
      r_err   <= w_oob;
      r_rdata <= (w_oob || r_we) ? 32'd0 : r_mem[w_idx];
    end
  end

  // Storage deliberately has no reset; a reset only ever blocks the pending access.
  always_ff @(posedge clk) begin
    if (w_access && r_we && !w_oob) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

`ifdef DATAMEM_STATS_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (w_done && !r_err) begin
      if (!r_we && r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
      if (r_we && r_wr_count != 16'hFFFF)  r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign bus.rd_count = r_rd_count;
  assign bus.wr_count = r_wr_count;
`else
  assign bus.rd_count = 16'd0;
  assign bus.wr_count = 16'd0;
`endif
endmodule

// File: tb/tb_datamem_resp.sv
// Randomized self-checking bench for datamem_resp against a word-array reference model.
module tb_datamem_resp;
  localparam int AW  = 17;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checkCount = 0;
  int   passCount  = 0;
  int   mRd = 0;
  int   mWr = 0;
  logic [31:0] model [int];

  datamem_resp_if bus ();

  datamem_resp #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic oob(input logic [31:0] addr);
    return addr >= (32'd1 << AW);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (oob(addr)) return 32'd0;
    if (!model.exists(int'(addr >> 2))) return 32'hxxxxxxxx;
    return model[int'(addr >> 2)];
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [3:0] be,
                                      input logic [31:0] wdata);
    logic [31:0] word;
    logic [31:0] mask;
    if (oob(addr)) return;
    word = model.exists(int'(addr >> 2)) ? model[int'(addr >> 2)] : 32'd0;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    model[int'(addr >> 2)] = (word & ~mask) | (wdata & mask);
  endfunction

  // Drives one request; waits are bounded, an expired wait shows up as a latency of 50.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input logic rr,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_be     = be;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    bus.resp_ready = rr;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (n >= 50) lat = 50;
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    if (rr) begin
      @(posedge clk); #1;
      if (!oob(addr)) begin
        if (we) mWr++; else mRd++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mRd = 0; mWr = 0;
    @(posedge clk); #1;
    checkCount++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
      $display("[TB] FAIL reset_handshake: req_ready=%b resp_valid=%b, required 0/0",
               bus.req_ready, bus.resp_valid);
    end else passCount++;
    checkCount++;
    if (bus.resp_rdata !== 32'd0 || bus.resp_err !== 1'b0 ||
        bus.rd_count !== 16'd0 || bus.wr_count !== 16'd0) begin
      $display("[TB] FAIL reset_outputs: rdata=%h err=%b rd=%0d wr=%0d, required all 0",
               bus.resp_rdata, bus.resp_err, bus.rd_count, bus.wr_count);
    end else passCount++;
    rst = 1'b0;
    #1;
    checkCount++;
    if (bus.req_ready !== 1'b1) begin
      $display("[TB] FAIL reset_release_ready: req_ready=%b, required 1", bus.req_ready);
    end else passCount++;
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic        er;
    int          lt;
    do_txn(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b1, rd, er, lt);
    model_write(32'h100, 4'hF, 32'hDEADBEEF);
    checkCount++;
    if (lt !== LAT || er !== 1'b0 || rd !== 32'd0) begin
      $display("[TB] FAIL write_resp: lat=%0d err=%b rdata=%h, required %0d/0/00000000",
               lt, er, rd, LAT);
    end else passCount++;
    do_txn(1'b0, 32'h100, 4'h0, 32'h0, 1'b1, rd, er, lt);
    checkCount++;
    if (lt !== LAT || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      $display("[TB] FAIL read_back: lat=%0d err=%b rdata=%h, required %0d/0/deadbeef",
               lt, er, rd, LAT);
    end else passCount++;
    do_txn(1'b1, 32'h300, 4'hF, 32'h11111111, 1'b1, rd, er, lt);
    model_write(32'h300, 4'hF, 32'h11111111);
    do_txn(1'b1, 32'h0, 4'hF, 32'h0BADF00D, 1'b1, rd, er, lt);
    model_write(32'h0, 4'hF, 32'h0BADF00D);
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    logic        er;
    int          lt;
    do_txn(1'b1, 32'h100, 4'b0010, 32'h0000AA00, 1'b1, rd, er, lt);
    model_write(32'h100, 4'b0010, 32'h0000AA00);
    do_txn(1'b0, 32'h103, 4'hF, 32'h0, 1'b1, rd, er, lt);
    checkCount++;
    if (rd !== 32'hDEADAAEF || rd !== model_read(32'h100)) begin
      $display("[TB] FAIL byte_lane: rdata=%h, required deadaaef", rd);
    end else passCount++;
    do_txn(1'b1, 32'h100, 4'b0000, 32'hFFFFFFFF, 1'b1, rd, er, lt);
    do_txn(1'b0, 32'h100, 4'h0, 32'h0, 1'b1, rd, er, lt);
    checkCount++;
    if (rd !== model_read(32'h100)) begin
      $display("[TB] FAIL be_zero_noop: rdata=%h, required %h", rd, model_read(32'h100));
    end else passCount++;
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic        er;
    int          lt;
    do_txn(1'b0, 32'h100, 4'hF, 32'h0, 1'b0, rd, er, lt);
    checkCount++;
    if (lt !== LAT || rd !== model_read(32'h100)) begin
      $display("[TB] FAIL bp_first: lat=%0d rdata=%h, required %0d/%h",
               lt, rd, LAT, model_read(32'h100));
    end else passCount++;
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h300;
      bus.req_be    = 4'hF;
      bus.req_wdata = 32'hBAD0BAD0;
      #1;
      checkCount++;
      if (bus.req_ready !== 1'b0) begin
        $display("[TB] FAIL bp_req_ready: cycle %0d req_ready=%b, required 0", i, bus.req_ready);
      end else passCount++;
      @(posedge clk); #1;
      checkCount++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== rd) begin
        $display("[TB] FAIL bp_hold: cycle %0d valid=%b rdata=%h, required 1/%h",
                 i, bus.resp_valid, bus.resp_rdata, rd);
      end else passCount++;
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    mRd++;
    checkCount++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      $display("[TB] FAIL bp_release: valid=%b req_ready=%b, required 0/1",
               bus.resp_valid, bus.req_ready);
    end else passCount++;
    do_txn(1'b0, 32'h300, 4'hF, 32'h0, 1'b1, rd, er, lt);
    checkCount++;
    if (rd !== 32'h11111111) begin
      $display("[TB] FAIL bp_ignored_req: rdata=%h, required 11111111", rd);
    end else passCount++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    logic        er;
    int          lt;
    do_txn(1'b0, 32'h0002_0000, 4'hF, 32'h0, 1'b1, rd, er, lt);
    checkCount++;
    if (er !== 1'b1 || rd !== 32'd0 || lt !== LAT) begin
      $display("[TB] FAIL oob_read: err=%b rdata=%h lat=%0d, required 1/00000000/%0d",
               er, rd, lt, LAT);
    end else passCount++;
    do_txn(1'b1, 32'h0002_0000, 4'hF, 32'hFEEDFACE, 1'b1, rd, er, lt);
    checkCount++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      $display("[TB] FAIL oob_write: err=%b rdata=%h, required 1/00000000", er, rd);
    end else passCount++;
    do_txn(1'b0, 32'h0, 4'hF, 32'h0, 1'b1, rd, er, lt);
    checkCount++;
    if (rd !== model_read(32'h0) || er !== 1'b0) begin
      $display("[TB] FAIL oob_alias: rdata=%h err=%b, required %h/0", rd, er, model_read(32'h0));
    end else passCount++;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    logic        er;
    int          lt;
    do_txn(1'b1, 32'h200, 4'hF, 32'hCAFEF00D, 1'b1, rd, er, lt);
    model_write(32'h200, 4'hF, 32'hCAFEF00D);
    do_txn(1'b0, 32'h200, 4'hF, 32'h0, 1'b1, rd, er, lt);
    bus.req_we = 1'b1; bus.req_addr = 32'h200; bus.req_be = 4'hF;
    bus.req_wdata = 32'h12345678; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    mRd = 0; mWr = 0;
    #1;
    checkCount++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 ||
        bus.resp_rdata !== 32'd0 || bus.resp_err !== 1'b0) begin
      $display("[TB] FAIL midwait_reset: ready=%b valid=%b rdata=%h err=%b, required 0/0/0/0",
               bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
    end else passCount++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkCount++;
      if (bus.resp_valid !== 1'b0) begin
        $display("[TB] FAIL midwait_no_resp: cycle %0d valid=%b, required 0", i, bus.resp_valid);
      end else passCount++;
    end
    do_txn(1'b0, 32'h200, 4'hF, 32'h0, 1'b1, rd, er, lt);
    checkCount++;
    if (rd !== 32'hCAFEF00D) begin
      $display("[TB] FAIL midwait_storage: rdata=%h, required cafef00d", rd);
    end else passCount++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [31:0] wd;
    logic        er;
    int          lt;
    for (int i = 0; i < 4; i++) begin
      wd = $urandom;
      do_txn(1'b1, 32'h800 + 32'(i * 4), 4'hF, wd, 1'b1, rd, er, lt);
      model_write(32'h800 + 32'(i * 4), 4'hF, wd);
      checkCount++;
      if (bus.req_ready !== 1'b1) begin
        $display("[TB] FAIL b2b_ready: req_ready=%b, required 1", bus.req_ready);
      end else passCount++;
      do_txn(1'b0, 32'h800 + 32'(i * 4), 4'h0, 32'h0, 1'b1, rd, er, lt);
      checkCount++;
      if (rd !== wd) begin
        $display("[TB] FAIL b2b_raw: rdata=%h, required %h", rd, wd);
      end else passCount++;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] exp;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        we;
    logic        rr;
    logic        er;
    int          lt;
    for (int w = 0; w < 8; w++) begin
      wd = $urandom;
      do_txn(1'b1, 32'h400 + 32'(w * 4), 4'hF, wd, 1'b1, rd, er, lt);
      model_write(32'h400 + 32'(w * 4), 4'hF, wd);
    end
    for (int i = 0; i < 40; i++) begin
      addr = 32'h400 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) addr = addr + 32'h0002_0000 + 32'($urandom_range(0, 3) << 20);
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      rr = 1'($urandom_range(0, 1));
      exp = we ? 32'd0 : model_read(addr);
      do_txn(we, addr, be, wd, rr, rd, er, lt);
      if (we) model_write(addr, be, wd);
      if (!rr) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        if (!oob(addr)) begin
          if (we) mWr++; else mRd++;
        end
      end
      checkCount++;
      if (rd !== exp || er !== oob(addr) || lt !== LAT || bus.resp_valid !== 1'b0) begin
        $display("[TB] FAIL rand_txn%0d: addr=%h we=%b rdata=%h err=%b lat=%0d valid=%b, required %h/%b/%0d/0",
                 i, addr, we, rd, er, lt, bus.resp_valid, exp, oob(addr), LAT);
      end else passCount++;
    end
  endtask

  task automatic test_counters();
    logic [31:0] rd;
    logic        er;
    int          lt;
    int          expRd;
    int          expWr;
    rst = 1'b1;
    mRd = 0; mWr = 0;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) do_txn(1'b0, 32'h100, 4'hF, 32'h0, 1'b1, rd, er, lt);
    for (int i = 0; i < 2; i++) do_txn(1'b1, 32'h104, 4'hF, 32'h5A5A0000 + 32'(i), 1'b1, rd, er, lt);
    model_write(32'h104, 4'hF, 32'h5A5A0001);
    do_txn(1'b0, 32'h0004_0000, 4'hF, 32'h0, 1'b1, rd, er, lt);
`ifdef DATAMEM_STATS_EN
    expRd = mRd;
    expWr = mWr;
`else
    expRd = 0;
    expWr = 0;
`endif
    checkCount++;
    if (bus.rd_count !== 16'(expRd) || bus.wr_count !== 16'(expWr) || mRd != 3 || mWr != 2) begin
      $display("[TB] FAIL stats: rd=%0d wr=%0d, required %0d/%0d", bus.rd_count, bus.wr_count,
               expRd, expWr);
    end else passCount++;
  endtask

  task automatic test_random_stats();
    int expRd;
    int expWr;
    test_random();
`ifdef DATAMEM_STATS_EN
    expRd = mRd;
    expWr = mWr;
`else
    expRd = 0;
    expWr = 0;
`endif
    checkCount++;
    if (bus.rd_count !== 16'(expRd) || bus.wr_count !== 16'(expWr)) begin
      $display("[TB] FAIL rand_stats: rd=%0d wr=%0d, required %0d/%0d", bus.rd_count,
               bus.wr_count, expRd, expWr);
    end else passCount++;
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_we     = 1'b0;
    bus.req_be     = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    #2;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_backpressure();
    test_out_of_range();
    test_reset_mid_wait();
    test_back_to_back();
    test_counters();
    test_random_stats();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/datamem_resp.md
Name: datamem_resp

Overview:
- Multi-cycle data-memory responder: the target end of the CPU load/store interface.
- Accepts one request at a time over a valid/ready handshake, models configurable access latency, then returns a response over a second valid/ready handshake.
- Supports byte-lane writes, for sb/sh/sw.
- Replaces the single-cycle data memory when the CPU moves to a stalling or pipelined memory stage.

Parameters:
- ADDR_WIDTH, 17: byte-address span. Storage is 2^(ADDR_WIDTH-2) 32-bit words.
- LATENCY, 2: cycles from request accept to resp_valid. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address. Bits [1:0] are ignored for lane selection.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  4  byte enables. Bit i selects lane [8i+7:8i].
- req_wdata  in  32  write data, lane-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  read data: full word, all lanes. 0 for writes and errors.
- resp_err  out  1  out-of-range address.
- rd_count  out  16  completed read counter (see Optional Feature).
- wr_count  out  16  completed write counter (see Optional Feature).

Behaviour:
- States: IDLE, WAIT, RESP. The state register and the latched request registers use async reset on rst.
- Reset (rst=1, any state, including mid-transaction):
  - state goes to IDLE; the latched request is discarded and no write occurs.
  - req_ready=0 while rst is high; resp_valid=0, resp_rdata=0, resp_err=0.
  - Storage contents are not cleared.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready: latch addr/we/be/wdata, load the counter with LATENCY-1, go to WAIT.
- WAIT:
  - req_ready=0.
  - The counter decrements each cycle. When the counter is 0, perform the access on this edge and go to RESP.
  - Net timing: request accepted at edge T gives resp_valid high in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after accept.
- Access:
  - Range check: addr >= 2^ADDR_WIDTH gives err=1, no write, rdata=0.
  - Write: lanes with be[i]=1 are updated; other lanes are unchanged. be=0 is a legal no-op write.
  - Read: rdata is the full word at addr[ADDR_WIDTH-1:2]. be is ignored.
- RESP:
  - resp_valid=1. rdata and err stay stable until the handshake.
  - On resp_ready=1: go to IDLE; resp_valid drops next cycle.
  - If resp_ready is already 1 on entry, the response completes in one cycle.
  - req_ready=0 throughout RESP. A new request can be accepted at the earliest one cycle after the response handshake.
- req_valid asserted outside IDLE is ignored. The requester must hold the request stable until req_ready is seen.
- Read-after-write to the same word, issued back to back, returns the new data.
- Outputs are registered, except req_ready, which is decoded from state and rst.

Optional Feature:
- Macro: DATAMEM_STATS_EN.
- Defined:
  - rd_count and wr_count increment on each non-error response handshake of the matching type.
  - Both saturate at 16'hFFFF and reset to 0 on rst.
  - Error responses are not counted.
- Not defined: rd_count and wr_count are tied to 0, and no counter flops are synthesised.

Test Plan:
1. LATENCY=2: write addr 0x100, be=4'hF, wdata 0xDEADBEEF, resp_ready=1 -> resp_valid exactly 2 cycles after accept, err=0, rdata=0. A following read of 0x100 returns 0xDEADBEEF.
2. Byte lanes: after test 1, write 0x100, be=4'b0010, wdata 0x0000AA00 -> a read of 0x100 returns 0xDEADAAEF.
3. Backpressure: read with resp_ready=0 for 5 cycles -> resp_valid stays 1 and rdata stays stable for all 5 cycles. req_valid pulsed meanwhile is not accepted (req_ready=0). Raising resp_ready completes the read, and IDLE follows next cycle.
4. Out of range: read at 0x0002_0000 (ADDR_WIDTH=17) -> err=1, rdata=0. A write to the same address leaves all storage unchanged.
5. Reset mid-WAIT: accept a write to 0x200 with wdata 0x12345678, assert rst during WAIT -> outputs return to reset values immediately, no resp_valid, and a later read of 0x200 returns the prior contents.
6. With DATAMEM_STATS_EN: 3 reads, 2 writes and 1 error read -> rd_count=3, wr_count=2. Without the macro, both counters read 0.
